instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Consumer side of the program counter interface. Reads the current 9-bit PC, issues a synchronous read to the 512x16 instruction memory, and captures the returned word into an instruction register.
- Presents the instruction to decode with a valid/ready handshake.
- Drives the PC control inputs: load_PC (increment) and imJumpFlag/imJump (absolute load). Sits between the program counter, instruction memory and decode stage.

Parameters:
- ADDR_W, 9, instruction address width; must match the PC width.
- INSTR_W, 16, instruction word width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_in  input  ADDR_W  current PC value (PCout of the program counter).
- fetch_en  input  1  permits new fetch requests when high.
- redirect  input  1  one-cycle pulse from execute: a taken branch or jump.
- redirect_addr  input  ADDR_W  absolute target for redirect.
- mem_rd  output  1  instruction memory read strobe.
- mem_addr  output  ADDR_W  instruction memory address.
- mem_rdata  input  INSTR_W  read data, valid the cycle after mem_rd.
- load_PC  output  1  PC increment request, one cycle wide.
- imJump  output  ADDR_W  PC absolute-load value.
- imJumpFlag  output  1  PC absolute-load strobe.
- instr_out  output  INSTR_W  registered instruction.
- instr_pc  output  ADDR_W  address that instr_out was fetched from.
- instr_valid  output  1  instr_out is valid for decode.
- instr_ready  input  1  decode accepts instr_out this cycle.
- bp_taken  output  1  instr_out was predecoded as taken (see Optional Feature).

Behaviour:
- Reset: state=S_REQ; instr_out=0; instr_pc=0; instr_valid=0; bp_taken=0; mem_rd=0; load_PC=0; imJumpFlag=0; imJump=0. Reset takes priority over every other input.
- FSM with three states: S_REQ, S_WAIT, S_HOLD.
- S_REQ, fetch_en=1 and redirect=0:
  - mem_rd=1, mem_addr=pc_in, req_addr<=pc_in, go to S_WAIT.
  - Otherwise mem_rd=0 and stay in S_REQ.
- S_WAIT, redirect=0:
  - instr_out<=mem_rdata, instr_pc<=req_addr.
  - load_PC=1 for exactly this cycle; the PC becomes req_addr+1 at this edge.
  - Go to S_HOLD.
- S_HOLD:
  - instr_valid=1 and instr_out is stable.
  - If instr_ready=1, the transfer completes at this edge, instr_valid drops next cycle, and the state goes to S_REQ.
  - Otherwise stay in S_HOLD; load_PC=0 and mem_rd=0 throughout.
- Latency and throughput:
  - PC sampled, then instruction valid 2 cycles later.
  - With ready held high, steady-state throughput is 1 instruction per 3 cycles.
- Redirect, in any state:
  - Combinationally drive imJumpFlag=1 and imJump=redirect_addr in the same cycle; load_PC=0.
  - Next state is S_REQ, which sees the new PC.
  - instr_valid<=0, so any held instruction is killed even if instr_ready=1 in the same cycle.
  - Any in-flight memory word (S_WAIT) is discarded.
- When no jump is issued, imJumpFlag=0 and imJump=0.
- load_PC and imJumpFlag are never both high in one cycle.
- fetch_en low does not abort S_WAIT or S_HOLD; it only blocks new requests from S_REQ.
- PC wrap-around is owned by the program counter: 9'h1FF+1=9'h000. The fetch unit imposes no boundary.
- Reset mid-fetch: returns to S_REQ next cycle with outputs at reset values; the returned memory word is ignored.

Optional Feature:
- Macro: IFETCH_BRANCH_PREDECODE_EN.
- With the macro defined, in S_WAIT with redirect=0:
  - If mem_rdata[15:13]==3'b001 and mem_rdata[10:8]==3'b000 (unconditional B), then imJumpFlag=1.
  - imJump = req_addr + 1 + sign_extend(mem_rdata[7:0]), truncated to ADDR_W bits; load_PC=0.
  - bp_taken<=1 together with the captured instruction.
  - Execute must then not redirect for that instruction.
  - An external redirect in the same cycle overrides the predecode.
- Without the macro: no predecode, bp_taken is tied to 0, and imJumpFlag is driven only by redirect.

Test Plan:
- Reset with pc_in=0, mem[0]=16'hD105, instr_ready=1 → mem_rd at cycle 1 with mem_addr=0; load_PC pulse at cycle 2; instr_valid with instr_out=16'hD105 and instr_pc=0 at cycle 3.
- Sequential fetch of mem[0..3], ready high → exactly one load_PC pulse per 3 cycles; instr_pc goes 0,1,2,3.
- instr_ready held low 5 cycles in S_HOLD → instr_out stable and instr_valid high, with no mem_rd and no load_PC; completes on the first ready.
- Redirect to 9'h040 asserted during S_WAIT → imJumpFlag=1 and imJump=9'h040 that cycle; load_PC=0; word discarded; next mem_addr=9'h040.
- pc_in=9'h1FF → fetch at 9'h1FF, then load_PC; next fetch at 9'h000.
- With IFETCH_BRANCH_PREDECODE_EN and mem[9'h010]=16'h2003 → imJumpFlag=1 and imJump=9'h014; bp_taken=1; next fetch at 9'h014. Without the macro, the next fetch is at 9'h011 and bp_taken=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC -> 512x16 sync-read memory -> instruction register -> decode (valid/ready).
// Optional macro IFETCH_BRANCH_PREDECODE_EN enables unconditional-branch predecode in S_WAIT.
module instr_fetch_unit #(
    parameter int ADDR_W  = 9,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               fetch_en,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               load_PC,
    output logic [ADDR_W-1:0]  imJump,
    output logic               imJumpFlag,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               bp_taken
);

    // Handshake: instr_out/instr_pc/bp_taken are held stable while instr_valid is high;
    // a transfer completes on a rising edge where instr_valid && instr_ready, unless
    // redirect is high in that same cycle, which kills the held instruction.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
    logic [INSTR_W-1:0]   instr_out_q, instr_out_d;
    logic [ADDR_W-1:0]    instr_pc_q, instr_pc_d;
    logic                 instr_valid_q, instr_valid_d;
    logic                 bp_taken_q, bp_taken_d;

    logic                 pd_hit;
    logic [ADDR_W-1:0]    pd_target;

`ifdef IFETCH_BRANCH_PREDECODE_EN
    // Unconditional B: opcode 001, condition field 000, signed 8-bit PC-relative offset.
    assign pd_hit    = (mem_rdata[15:13] == 3'b001) && (mem_rdata[10:8] == 3'b000);
    assign pd_target = req_addr_q + ADDR_W'(1) + ADDR_W'($signed(mem_rdata[7:0]));
`else
    assign pd_hit    = 1'b0;
    assign pd_target = '0;
`endif

    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        bp_taken_d    = bp_taken_q;
        mem_rd        = 1'b0;
        mem_addr      = pc_in;
        load_PC       = 1'b0;
        imJumpFlag    = 1'b0;
        imJump        = '0;

        if (reset) begin
            state_d = S_REQ;
        end else if (redirect) begin
            // Execute redirect wins in every state; any in-flight word is dropped.
            imJumpFlag    = 1'b1;
            imJump        = redirect_addr;
            instr_valid_d = 1'b0;
            bp_taken_d    = 1'b0;
            state_d       = S_REQ;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (fetch_en) begin
                        mem_rd     = 1'b1;
                        req_addr_d = pc_in;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    instr_out_d   = mem_rdata;
                    instr_pc_d    = req_addr_q;
                    instr_valid_d = 1'b1;
                    bp_taken_d    = pd_hit;
                    if (pd_hit) begin
                        imJumpFlag = 1'b1;
                        imJump     = pd_target;
                    end else begin
                        load_PC = 1'b1;
                    end
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        instr_valid_d = 1'b0;
                        bp_taken_d    = 1'b0;
                        state_d       = S_REQ;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_REQ;
            req_addr_q    <= '0;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            bp_taken_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            bp_taken_q    <= bp_taken_d;
        end
    end

    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign bp_taken    = bp_taken_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural PC + 512x16 sync memory around the DUT, per-cycle vectors.
module tb_instr_fetch_unit;

`ifdef IFETCH_BRANCH_PREDECODE_EN
    localparam bit PD = 1'b1;
`else
    localparam bit PD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  pc_in;
    logic        fetch_en;
    logic        redirect;
    logic [8:0]  redirect_addr;
    logic        mem_rd;
    logic [8:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        load_PC;
    logic [8:0]  imJump;
    logic        imJumpFlag;
    logic [15:0] instr_out;
    logic [8:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        bp_taken;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [512];
    logic [8:0]  pc_q;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(9), .INSTR_W(16)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .fetch_en(fetch_en),
        .redirect(redirect), .redirect_addr(redirect_addr),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .load_PC(load_PC), .imJump(imJump), .imJumpFlag(imJumpFlag),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .bp_taken(bp_taken)
    );

    // Program counter and instruction memory surrounding the fetch unit.
    always @(posedge clk) begin
        if (reset) pc_q <= 9'd0;
        else if (imJumpFlag) pc_q <= imJump;
        else if (load_PC) pc_q <= pc_q + 9'd1;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end
    assign pc_in = pc_q;

    typedef struct {
        logic        rst, fen, redir;
        logic [8:0]  raddr;
        logic        rdy;
        logic        e_rd;
        logic [8:0]  e_addr;
        logic        e_ld, e_jf;
        logic [8:0]  e_j;
        logic        e_vld;
        logic [15:0] e_out;
        logic [8:0]  e_ipc;
        logic        e_bp;
        logic        chk_io;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, fen, redir, input logic [8:0] raddr, input logic rdy,
                                input logic e_rd, input logic [8:0] e_addr, input logic e_ld, e_jf,
                                input logic [8:0] e_j, input logic e_vld, input logic [15:0] e_out,
                                input logic [8:0] e_ipc, input logic e_bp, chk_io);
        vec_t v;
        v.rst = rst; v.fen = fen; v.redir = redir; v.raddr = raddr; v.rdy = rdy;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_ld = e_ld; v.e_jf = e_jf; v.e_j = e_j;
        v.e_vld = e_vld; v.e_out = e_out; v.e_ipc = e_ipc; v.e_bp = e_bp; v.chk_io = chk_io;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int cyc = 0;

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset = v.rst; fetch_en = v.fen; redirect = v.redir;
        redirect_addr = v.raddr; instr_ready = v.rdy;
        #2;
        check($sformatf("c%0d mem_rd", cyc), 32'(mem_rd), 32'(v.e_rd));
        if (v.e_rd) check($sformatf("c%0d mem_addr", cyc), 32'(mem_addr), 32'(v.e_addr));
        check($sformatf("c%0d load_PC", cyc), 32'(load_PC), 32'(v.e_ld));
        check($sformatf("c%0d imJumpFlag", cyc), 32'(imJumpFlag), 32'(v.e_jf));
        check($sformatf("c%0d imJump", cyc), 32'(imJump), 32'(v.e_j));
        check($sformatf("c%0d instr_valid", cyc), 32'(instr_valid), 32'(v.e_vld));
        if (v.e_vld || v.chk_io) begin
            check($sformatf("c%0d instr_out", cyc), 32'(instr_out), 32'(v.e_out));
            check($sformatf("c%0d instr_pc", cyc), 32'(instr_pc), 32'(v.e_ipc));
        end
        check($sformatf("c%0d bp_taken", cyc), 32'(bp_taken), 32'(v.e_bp));
        check($sformatf("c%0d strobe_excl", cyc), 32'(load_PC & imJumpFlag), 32'd0);
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[9'h000] = 16'hD105; mem[9'h001] = 16'h4A01; mem[9'h002] = 16'h5B02;
        mem[9'h003] = 16'h6C03; mem[9'h004] = 16'h3704; mem[9'h040] = 16'h7E40;
        mem[9'h1FF] = 16'h81FF; mem[9'h010] = 16'h2003; mem[9'h011] = 16'h9011;
        mem[9'h014] = 16'hA014; mem[9'h0A0] = 16'hC0A0;
        mem_rdata = 16'h0;

        //               rst fen red raddr   rdy  rd addr    ld jf j       vld out       ipc    bp chk
        vecs.push_back(mk(1, 1, 0, 9'h000, 1,  0, 9'h000,  0, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 1)); // reset state
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  1, 9'h000,  0, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0)); // req @0
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  0, 9'h000,  1, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  0, 9'h000,  0, 0, 9'h000, 1, 16'hD105, 9'h000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  1, 9'h001,  0, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0)); // req @1
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  0, 9'h000,  1, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  0, 9'h000,  0, 0, 9'h000, 1, 16'h4A01, 9'h001, 0, 0));
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  1, 9'h002,  0, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0)); // req @2
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  0, 9'h000,  1, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 9'h000, 0,  0, 9'h000,  0, 0, 9'h000, 1, 16'h5B02, 9'h002, 0, 0)); // stall x5
        vecs.push_back(mk(0, 0, 0, 9'h000, 0,  0, 9'h000,  0, 0, 9'h000, 1, 16'h5B02, 9'h002, 0, 0));
        vecs.push_back(mk(0, 0, 0, 9'h000, 0,  0, 9'h000,  0, 0, 9'h000, 1, 16'h5B02, 9'h002, 0, 0));
        vecs.push_back(mk(0, 1, 0, 9'h000, 0,  0, 9'h000,  0, 0, 9'h000, 1, 16'h5B02, 9'h002, 0, 0));
        vecs.push_back(mk(0, 1, 0, 9'h000, 0,  0, 9'h000,  0, 0, 9'h000, 1, 16'h5B02, 9'h002, 0, 0));
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  0, 9'h000,  0, 0, 9'h000, 1, 16'h5B02, 9'h002, 0, 0));
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  1, 9'h003,  0, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0)); // req @3
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  0, 9'h000,  1, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  0, 9'h000,  0, 0, 9'h000, 1, 16'h6C03, 9'h003, 0, 0));
        vecs.push_back(mk(0, 0, 0, 9'h000, 1,  0, 9'h000,  0, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0)); // fetch_en low
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  1, 9'h004,  0, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0)); // req @4
        vecs.push_back(mk(0, 1, 1, 9'h040, 1,  0, 9'h000,  0, 1, 9'h040, 0, 16'h0000, 9'h000, 0, 0)); // redirect in WAIT
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  1, 9'h040,  0, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  0, 9'h000,  1, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 9'h1FF, 1,  0, 9'h000,  0, 1, 9'h1FF, 1, 16'h7E40, 9'h040, 0, 0)); // kill held instr
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  1, 9'h1FF,  0, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0)); // req @1FF
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  0, 9'h000,  1, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  0, 9'h000,  0, 0, 9'h000, 1, 16'h81FF, 9'h1FF, 0, 0));
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  1, 9'h000,  0, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0)); // wrapped to 0
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  0, 9'h000,  1, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 9'h000, 0,  0, 9'h000,  0, 0, 9'h000, 1, 16'hD105, 9'h000, 0, 0));
        vecs.push_back(mk(0, 1, 1, 9'h010, 0,  0, 9'h000,  0, 1, 9'h010, 1, 16'hD105, 9'h000, 0, 0)); // redirect in HOLD
        vecs.push_back(mk(0, 1, 0, 9'h000, 1,  1, 9'h010,  0, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0)); // req @010

        reset = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_addr = 9'h0; instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Branch predecode on mem[010]=2003 (B +3): target 014 only when predecode is built in.
        apply(mk(0, 1, 0, 9'h000, 1,  0, 9'h000, !PD, PD, PD ? 9'h014 : 9'h000, 0, 16'h0000, 9'h000, 0, 0));
        apply(mk(0, 1, 0, 9'h000, 1,  0, 9'h000, 0, 0, 9'h000, 1, 16'h2003, 9'h010, PD, 0));
        apply(mk(0, 1, 0, 9'h000, 1,  1, PD ? 9'h014 : 9'h011, 0, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0));
        // Reset in S_WAIT, then a redirect issued from S_REQ.
        apply(mk(1, 1, 1, 9'h055, 1,  0, 9'h000, 0, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0));
        apply(mk(0, 1, 1, 9'h0A0, 1,  0, 9'h000, 0, 1, 9'h0A0, 0, 16'h0000, 9'h000, 0, 1));
        apply(mk(0, 1, 0, 9'h000, 1,  1, 9'h0A0, 0, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0));
        apply(mk(0, 1, 0, 9'h000, 1,  0, 9'h000, 1, 0, 9'h000, 0, 16'h0000, 9'h000, 0, 0));
        apply(mk(0, 1, 0, 9'h000, 1,  0, 9'h000, 0, 0, 9'h000, 1, 16'hC0A0, 9'h0A0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
